lfsr_checker: RTL and testbench

Serial receive-side checker for the LFSR pseudo-random stream: consumes one bit per valid cycle, self-synchronises to the generator's sequence, then counts bit errors against a locally predicted sequence. It sits at the sink end of LFSR-driven test and masking datapaths in the SCA platform, and verifies that the random stream arrives intact. Counters and status are held in registers so an AXI wrapper can read them.

---
 rtl/lfsr_checker.sv | 149 ++++++++++++++
 tb/tb_lfsr_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for a serial Fibonacci LFSR stream: self-synchronises to the
// generator, then flywheels on its own prediction and counts bit errors.
module lfsr_checker #(
   parameter int WIDTH      = 32,
   parameter int LOCK_COUNT = 16,
   parameter int ERR_LIMIT  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic                 in_bit,
   output logic                 locked,
   output logic                 bit_err,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic [CNT_WIDTH-1:0] bit_count
);

   // Feedback tap masks per supported length (bit i set = sh[i] is a tap).
   localparam logic [31:0] TAP_ALL = (WIDTH == 4)  ? 32'h0000_000C :
                                     (WIDTH == 8)  ? 32'h0000_00B8 :
                                     (WIDTH == 16) ? 32'h0000_D008 :
                                                     32'h8020_0003;
   localparam logic [WIDTH-1:0] TAPS = TAP_ALL[WIDTH-1:0];

   localparam int FILL_W  = $clog2(WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int RUN_W   = $clog2(ERR_LIMIT + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(ERR_LIMIT - 1);

   typedef enum logic [1:0] {
      S_FILL    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [WIDTH-1:0]     sh, sh_n;
   logic [FILL_W-1:0]    fill_cnt, fill_n;
   logic [MATCH_W-1:0]   match_cnt, match_n;
   logic [RUN_W-1:0]     run_cnt, run_n;
   logic                 bit_err_n;
   logic [CNT_WIDTH-1:0] err_n, bcnt_n;
   logic                 p;
   logic                 mismatch;
   logic [WIDTH-1:0]     shifted;

   assign p        = ^(sh & TAPS);
   assign mismatch = in_bit ^ p;
   assign shifted  = {sh[WIDTH-2:0], in_bit};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_FILL;
         sh        <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         run_cnt   <= '0;
         locked    <= 1'b0;
         bit_err   <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_n;
         sh        <= sh_n;
         fill_cnt  <= fill_n;
         match_cnt <= match_n;
         run_cnt   <= run_n;
         locked    <= (state_n == S_LOCKED);
         bit_err   <= bit_err_n;
         err_count <= err_n;
         bit_count <= bcnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      sh_n      = sh;
      fill_n    = fill_cnt;
      match_n   = match_cnt;
      run_n     = run_cnt;
      bit_err_n = 1'b0;
      err_n     = err_count;
      bcnt_n    = bit_count;

      if (in_valid) begin
         case (state)
            S_FILL: begin
               sh_n = shifted;
               if (fill_cnt == FILL_LAST) begin
                  fill_n = '0;
                  // An all-zero window is the LFSR lock-up state; keep filling.
                  if (shifted != '0) begin
                     state_n = S_ACQUIRE;
                     match_n = '0;
                  end
               end else begin
                  fill_n = fill_cnt + FILL_W'(1);
               end
            end
            S_ACQUIRE: begin
               sh_n = shifted;
               if (mismatch) begin
                  state_n = S_FILL;
                  fill_n  = '0;
               end else if (match_cnt == MATCH_LAST) begin
                  state_n = S_LOCKED;
                  match_n = '0;
                  run_n   = '0;
               end else begin
                  match_n = match_cnt + MATCH_W'(1);
               end
            end
            S_LOCKED: begin
               // Flywheel: follow our own prediction so a flipped bit does not poison sh.
               sh_n = {sh[WIDTH-2:0], p};
               if (bit_count != '1) bcnt_n = bit_count + CNT_WIDTH'(1);
               if (mismatch) begin
                  bit_err_n = 1'b1;
                  if (err_count != '1) err_n = err_count + CNT_WIDTH'(1);
                  if (run_cnt == RUN_LAST) begin
                     state_n = S_FILL;
                     fill_n  = '0;
                     run_n   = '0;
                  end else begin
                     run_n = run_cnt + RUN_W'(1);
                  end
               end else begin
                  run_n = '0;
               end
            end
            default: begin
               state_n = S_FILL;
               fill_n  = '0;
            end
         endcase
      end

      if (clear) begin
         err_n  = '0;
         bcnt_n = '0;
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: an 8-bit instance for lock/flywheel/clear/reset
// behaviour and a 32-bit instance with narrow counters for gaps and saturation.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        v8, b8, clr8;
   logic        v32, b32, clr32;
   logic        locked8, bit_err8;
   logic [15:0] err8, bcnt8;
   logic        locked32, bit_err32;
   logic [3:0]  err32, bcnt32;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  g8;
   logic [31:0] g32;

   always #5 clk = ~clk;

   lfsr_checker #(.WIDTH(8), .LOCK_COUNT(16), .ERR_LIMIT(4), .CNT_WIDTH(16)) u8 (
      .clk(clk), .reset_n(reset_n), .clear(clr8), .in_valid(v8), .in_bit(b8),
      .locked(locked8), .bit_err(bit_err8), .err_count(err8), .bit_count(bcnt8)
   );

   lfsr_checker #(.WIDTH(32), .LOCK_COUNT(16), .ERR_LIMIT(4), .CNT_WIDTH(4)) u32 (
      .clk(clk), .reset_n(reset_n), .clear(clr32), .in_valid(v32), .in_bit(b32),
      .locked(locked32), .bit_err(bit_err32), .err_count(err32), .bit_count(bcnt32)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generator models: emit MSB, shift left, feedback into LSB.
   task automatic clean8(input logic flip = 1'b0);
      v8 = 1'b1;
      b8 = g8[7] ^ flip;
      g8 = {g8[6:0], g8[7] ^ g8[5] ^ g8[4] ^ g8[3]};
      tick();
   endtask

   task automatic gap8();
      v8 = 1'b0;
      b8 = 1'($urandom_range(0, 1));
      tick();
   endtask

   task automatic clean32(input logic flip = 1'b0);
      v32 = 1'b1;
      b32 = g32[31] ^ flip;
      g32 = {g32[30:0], g32[31] ^ g32[21] ^ g32[1] ^ g32[0]};
      tick();
   endtask

   task automatic gap32();
      v32 = 1'b0;
      b32 = 1'($urandom_range(0, 1));
      tick();
   endtask

   initial begin
      logic sticky;
      int   vcnt;
      int   m;

      reset_n = 1'b0;
      v8 = 1'b0; b8 = 1'b0; clr8 = 1'b0;
      v32 = 1'b0; b32 = 1'b0; clr32 = 1'b0;
      tick();
      tick();
      check("rst8_locked", 32'(locked8), 0);
      check("rst8_bit_err", 32'(bit_err8), 0);
      check("rst8_err", 32'(err8), 0);
      check("rst8_bcnt", 32'(bcnt8), 0);
      check("rst32_locked", 32'(locked32), 0);
      check("rst32_bcnt", 32'(bcnt32), 0);
      reset_n = 1'b1;

      // Clean stream from seed 0x01: lock right after the 24th bit.
      g8 = 8'h01;
      for (int i = 1; i <= 24; i++) begin
         clean8();
         if (i == 23) check("lock8_before", 32'(locked8), 0);
      end
      check("lock8_at24", 32'(locked8), 1);
      check("lock8_bcnt0", 32'(bcnt8), 0);

      sticky = 1'b0;
      for (int i = 0; i < 100; i++) begin
         clean8();
         sticky = sticky | bit_err8;
      end
      check("run100_bcnt", 32'(bcnt8), 100);
      check("run100_err", 32'(err8), 0);
      check("run100_no_bit_err", 32'(sticky), 0);

      // Single flipped bit: one pulse, lock held, flywheel keeps later bits clean.
      clean8(1'b1);
      check("flip1_bit_err", 32'(bit_err8), 1);
      check("flip1_err", 32'(err8), 1);
      check("flip1_locked", 32'(locked8), 1);
      check("flip1_bcnt", 32'(bcnt8), 101);
      clean8();
      check("flip1_pulse_end", 32'(bit_err8), 0);
      for (int i = 0; i < 20; i++) clean8();
      check("flywheel_err", 32'(err8), 1);
      check("flywheel_bcnt", 32'(bcnt8), 122);
      check("flywheel_locked", 32'(locked8), 1);

      // Four consecutive errors drop lock; the 4th still counts.
      for (int i = 1; i <= 3; i++) clean8(1'b1);
      check("burst3_locked", 32'(locked8), 1);
      clean8(1'b1);
      check("burst4_locked", 32'(locked8), 0);
      check("burst4_bit_err", 32'(bit_err8), 1);
      check("burst4_err", 32'(err8), 5);
      check("burst4_bcnt", 32'(bcnt8), 126);
      for (int i = 1; i <= 24; i++) begin
         clean8();
         if (i == 23) check("relock_before", 32'(locked8), 0);
      end
      check("relock_at24", 32'(locked8), 1);
      check("relock_bcnt", 32'(bcnt8), 126);

      // Clear, including clear on the same cycle as an error.
      clr8 = 1'b1;
      clean8();
      check("clear_err", 32'(err8), 0);
      check("clear_bcnt", 32'(bcnt8), 0);
      clean8(1'b1);
      check("clear_err_same_cycle", 32'(err8), 0);
      check("clear_bit_err_kept", 32'(bit_err8), 1);
      check("clear_bcnt_same_cycle", 32'(bcnt8), 0);
      clr8 = 1'b0;
      clean8();
      check("post_clear_bcnt", 32'(bcnt8), 1);
      check("post_clear_err", 32'(err8), 0);

      // Gaps hold state; bit_err drops during a gap.
      clean8(1'b1);
      check("pregap_bit_err", 32'(bit_err8), 1);
      gap8();
      check("gap_bit_err", 32'(bit_err8), 0);
      check("gap_err_hold", 32'(err8), 1);
      check("gap_bcnt_hold", 32'(bcnt8), 2);
      gap8();
      check("gap_locked_hold", 32'(locked8), 1);
      clean8();
      check("after_gap_err", 32'(err8), 1);
      check("after_gap_bcnt", 32'(bcnt8), 3);
      check("after_gap_bit_err", 32'(bit_err8), 0);

      // Reset while locked.
      reset_n = 1'b0;
      clean8();
      check("midrst_locked", 32'(locked8), 0);
      check("midrst_bit_err", 32'(bit_err8), 0);
      check("midrst_err", 32'(err8), 0);
      check("midrst_bcnt", 32'(bcnt8), 0);
      reset_n = 1'b1;

      // All-zero stream never locks.
      sticky = 1'b0;
      v8 = 1'b1;
      b8 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         sticky = sticky | locked8;
      end
      check("zeros_never_lock", 32'(sticky), 0);

      // Error on acquisition bit 5 forces a refill.
      g8 = 8'h01;
      for (int i = 0; i < 12; i++) clean8();
      clean8(1'b1);
      check("acq_err_locked", 32'(locked8), 0);
      for (int i = 1; i <= 24; i++) begin
         clean8();
         if (i == 23) check("acq_relock_before", 32'(locked8), 0);
      end
      check("acq_relock_at24", 32'(locked8), 1);
      v8 = 1'b0;

      // 32-bit stream with random gaps: lock after exactly 48 valid bits.
      g32 = 32'h0000_0001;
      vcnt = 0;
      for (int c = 0; c < 2000 && vcnt < 48; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            clean32();
            vcnt++;
            if (vcnt == 47) check("lock32_before", 32'(locked32), 0);
         end else begin
            gap32();
         end
      end
      check("lock32_at48", 32'(locked32), 1);
      check("lock32_bcnt0", 32'(bcnt32), 0);

      m = 0;
      for (int c = 0; c < 40; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            clean32();
            if (m < 15) m++;
         end else begin
            gap32();
            check("gap32_locked", 32'(locked32), 1);
            check("gap32_bit_err", 32'(bit_err32), 0);
         end
         check("gap32_bcnt", 32'(bcnt32), 32'(m));
      end

      // Isolated errors until err_count saturates at all-ones.
      for (int k = 1; k <= 20; k++) begin
         clean32(1'b1);
         check("sat_bit_err", 32'(bit_err32), 1);
         check("sat_err", 32'(err32), 32'((k < 15) ? k : 15));
         clean32();
      end
      check("sat_err_final", 32'(err32), 15);
      check("sat_bcnt_final", 32'(bcnt32), 15);
      check("sat_locked", 32'(locked32), 1);
      clr32 = 1'b1;
      clean32(1'b1);
      check("sat_clear_err", 32'(err32), 0);
      check("sat_clear_bit_err", 32'(bit_err32), 1);
      clr32 = 1'b0;

      reset_n = 1'b0;
      clean32();
      check("midrst32_locked", 32'(locked32), 0);
      check("midrst32_bit_err", 32'(bit_err32), 0);
      check("midrst32_err", 32'(err32), 0);
      check("midrst32_bcnt", 32'(bcnt32), 0);
      reset_n = 1'b1;
      v32 = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
